// File: rtl/mult_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_wb_arbiter_if
// Brief    : Multiplier result, main writeback and register-file write bundle
//            for mult_wb_arbiter. The fwd_* lines matter only with MULT_WB_FWD_EN.
// Revision : 1.0  initial release
// ============================================================================
interface mult_wb_arbiter_if;
    logic        mult_we;
    logic [4:0]  mult_addr;
    logic [31:0] mult_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] pend_flags;
    logic        mult_stall;
    logic        ovf_err;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    // Producer side: multiplier, pipeline writeback and hazard logic.
    modport master (
        output mult_we, mult_addr, mult_data, wb_we, wb_addr, wb_data, fwd_addr,
        input  rf_we, rf_addr, rf_data, pend_flags, mult_stall, ovf_err,
        input  fwd_hit, fwd_data
    );

    // Arbiter side.
    modport slave (
        input  mult_we, mult_addr, mult_data, wb_we, wb_addr, wb_data, fwd_addr,
        output rf_we, rf_addr, rf_data, pend_flags, mult_stall, ovf_err,
        output fwd_hit, fwd_data
    );
endinterface
`default_nettype wire

// File: rtl/mult_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_wb_arbiter
// Brief    : Merges the multiplier result stream into the shared register-file
//            write port; losing results wait in an ordered FIFO with squash.
//            Optional macro MULT_WB_FWD_EN adds a FIFO forwarding lookup.
// Revision : 1.0  initial release
// ============================================================================
module mult_wb_arbiter #(
    parameter int DEPTH     = 8,
    parameter int PPL_STAGE = 3,
    parameter int STALL_TH  = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mult_wb_arbiter_if.slave bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0] c_TH   = (c_AW+1)'(STALL_TH);

    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) ||
            (STALL_TH > DEPTH - PPL_STAGE - 1)) begin : g_param_chk
            $error("mult_wb_arbiter: illegal DEPTH/PPL_STAGE/STALL_TH");
        end
    endgenerate

    logic [c_AW-1:0]  r_head;
    logic [c_AW-1:0]  r_tail;
    logic [c_AW:0]    r_count;
    logic [DEPTH-1:0] r_valid;
    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic             r_ovf;
    logic             r_rf_we;
    logic [4:0]       r_rf_addr;
    logic [31:0]      r_rf_data;

    logic             w_mult_v;
    logic             w_wb_v;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_head_wr;
    logic             w_bypass;
    logic             w_push_req;
    logic             w_push;
    logic             w_ovf_evt;
    logic [DEPTH-1:0] w_squash;
    logic [31:0]      w_pend;

    assign w_mult_v = bus.mult_we && (bus.mult_addr != 5'd0);
    assign w_wb_v   = bus.wb_we && (bus.wb_addr != 5'd0);
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL);
    assign w_pop    = !w_wb_v && !w_empty;
    assign w_head_wr = w_pop && r_valid[r_head];
    // A dead head being popped frees the port, but the multiplier result may
    // only take it if nothing older remains behind that head.
    assign w_bypass = w_mult_v && !w_wb_v &&
                      (w_empty || (w_pop && !r_valid[r_head] && (r_count == (c_AW+1)'(1))));
    assign w_push_req = w_mult_v && !w_bypass;
    assign w_ovf_evt  = w_push_req && w_full && !w_pop;
    assign w_push     = w_push_req && !w_ovf_evt;

    always_comb begin
        w_squash = '0;
        w_pend   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wb_v && r_valid[i] && (r_addr[i] == bus.wb_addr))
                w_squash[i] = 1'b1;
            if (r_valid[i])
                w_pend[r_addr[i]] = 1'b1;
        end
        w_pend[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_valid   <= '0;
            r_ovf     <= 1'b0;
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            // Later assignments override: a push into the slot being popped
            // (full FIFO) must leave that slot valid.
            r_valid <= r_valid & ~w_squash;
            if (w_pop)
                r_valid[r_head] <= 1'b0;
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= bus.mult_addr;
                r_data[r_tail]  <= bus.mult_data;
            end
            r_head  <= r_head + c_AW'(w_pop);
            r_tail  <= r_tail + c_AW'(w_push);
            r_count <= r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
            if (w_ovf_evt)
                r_ovf <= 1'b1;

            if (w_wb_v) begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= bus.wb_addr;
                r_rf_data <= bus.wb_data;
            end else if (w_head_wr) begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= r_addr[r_head];
                r_rf_data <= r_data[r_head];
            end else if (w_bypass) begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= bus.mult_addr;
                r_rf_data <= bus.mult_data;
            end else begin
                r_rf_we   <= 1'b0;
            end
        end
    end

    assign bus.rf_we      = r_rf_we;
    assign bus.rf_addr    = r_rf_addr;
    assign bus.rf_data    = r_rf_data;
    assign bus.pend_flags = w_pend;
    assign bus.mult_stall = (r_count >= c_TH);
    assign bus.ovf_err    = r_ovf;

`ifdef MULT_WB_FWD_EN
    logic        w_fwd_hit;
    logic [31:0] w_fwd_data;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [c_AW-1:0] v_idx;
        v_idx      = '0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + c_AW'(k);
            if ((bus.fwd_addr != 5'd0) && r_valid[v_idx] && (r_addr[v_idx] == bus.fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[v_idx];
            end
        end
    end

    assign bus.fwd_hit  = w_fwd_hit;
    assign bus.fwd_data = w_fwd_data;
`else
    assign bus.fwd_hit  = 1'b0;
    assign bus.fwd_data = '0;
`endif

endmodule
`default_nettype wire

// File: doc/mult_wb_arbiter.md
Name: mult_wb_arbiter

Overview:
- Receiving end of the multiplier result interface: accepts the per-cycle result stream (we/addr/data) from the pipelined multiplier and merges it into the single register-file write port shared with the main pipeline writeback.
- Main writeback always wins the port. Multiplier results that lose arbitration are buffered in a small FIFO.
- Exports pending-destination flags for the hazard/stall logic, and a throttle signal that stops new multiply issue before the FIFO can overflow. The multiplier pipeline itself cannot be back-pressured.

Parameters:
- DEPTH, 8, FIFO entries. Power of two, minimum 4.
- PPL_STAGE, 3, multiplier pipeline depth (results in flight that cannot be stopped).
- STALL_TH, 4, occupancy at or above which mult_stall asserts. Must satisfy STALL_TH <= DEPTH-PPL_STAGE-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mult_we  in  1  multiplier result valid this cycle
- mult_addr  in  5  multiplier destination register
- mult_data  in  32  multiplier result
- wb_we  in  1  main pipeline writeback valid
- wb_addr  in  5  main pipeline destination register
- wb_data  in  32  main pipeline write data
- rf_we  out  1  register-file write enable (registered)
- rf_addr  out  5  register-file write address (registered)
- rf_data  out  32  register-file write data (registered)
- pend_flags  out  32  bit r = 1 while a valid FIFO entry targets register r; bit 0 always 0 (combinational from FIFO state)
- mult_stall  out  1  block issue of new multiply instructions (combinational)
- ovf_err  out  1  sticky overflow error
- fwd_addr  in  5  forwarding lookup address (MULT_WB_FWD_EN only)
- fwd_hit  out  1  lookup hit (MULT_WB_FWD_EN only)
- fwd_data  out  32  forwarded data (MULT_WB_FWD_EN only)

Behaviour:
- One clock domain (clk); reset synchronous, active-high (rst).
- Reset: rf_we=0, rf_addr=0, rf_data=0, FIFO count=0, all entries invalid, ovf_err=0. Reset mid-operation discards all buffered results without writing them.
- Input qualification: a writeback with addr 0 is treated as not valid. This applies to both mult_we and wb_we.
- Source select each cycle, in priority order:
  (1) wb valid → write wb_addr/wb_data.
  (2) else FIFO non-empty → write the head entry and pop it.
  (3) else mult valid → write mult_addr/mult_data directly (bypass, FIFO untouched).
  (4) else rf_we=0 next cycle.
  The selection is registered onto rf_* at the next clk edge: 1-cycle latency from input to rf_we.
- Enqueue: a valid mult result not chosen in (3) is pushed at the tail. Push and pop in the same cycle are allowed; count stays the same.
- Ordering: FIFO entries leave strictly in arrival order. A multiplier result never bypasses older buffered results.
- Squash: when wb is valid and wb_addr equals the address of any valid FIFO entry, those entries are invalidated in that cycle (the younger write wins).
  - An invalid entry still occupies its slot.
  - An invalid entry reaching the head is popped without a write, and (2) falls through to (3) that cycle.
- pend_flags: OR over valid entries only; the rf output register is not included.
- mult_stall = (count >= STALL_TH).
- Overflow: a push when count==DEPTH with no pop that cycle drops the incoming result and sets ovf_err. ovf_err clears only on rst.
- Wrap-around: head and tail pointers wrap modulo DEPTH. count ranges 0..DEPTH and is held in log2(DEPTH)+1 bits.
- Main writeback never stalls. Hazard logic upstream guarantees no multiplier result arrives for a register with a younger wb already written.

Optional Feature:
- Macro: MULT_WB_FWD_EN.
- Defined: fwd_hit=1 when fwd_addr!=0 and some valid FIFO entry matches fwd_addr; fwd_data is taken from the youngest matching valid entry. Both outputs are combinational.
- Undefined: fwd_hit=0, fwd_data=0, no compare logic; fwd_addr is ignored.

Test Plan:
- Bypass: FIFO empty, mult_we=1 addr=5 data=0x12345678, wb_we=0 → next cycle rf_we=1, rf_addr=5, rf_data=0x12345678; pend_flags stays 0.
- Conflict: same cycle mult (addr 3, 0xAAAA0000) and wb (addr 7, 0x11) → cycle+1 writes r7=0x11 and pend_flags[3]=1; cycle+2 writes r3=0xAAAA0000 and pend_flags returns to 0.
- Ordering/throttle: wb_we held high 6 cycles while mults to r1..r6 arrive each cycle → mult_stall rises once count hits 4; after wb drops, writes appear in order r1..r6 on consecutive cycles.
- Squash: buffer mult r9=0xDEAD, then wb r9=0xBEEF → rf sees r9=0xBEEF only; the r9 entry is popped silently and pend_flags[9] clears.
- Overflow/reset: fill 8 entries under continuous wb, push a 9th → ovf_err=1 and that data is never written; assert rst for 1 cycle → count=0, rf_we=0, ovf_err=0.
- Forwarding (MULT_WB_FWD_EN): buffer r4=0x1 then r4=0x2, fwd_addr=4 → fwd_hit=1, fwd_data=0x2; fwd_addr=0 → fwd_hit=0.
